// File: rtl/idct_block_scheduler_if.sv
// Request and IDCT-side signal bundle for the block scheduler.
// master = producers plus IDCT model, slave = scheduler.
interface idct_block_scheduler_if #(
  parameter int CH = 3
);
  localparam int CW = $clog2(CH + 1);

  logic [CH-1:0]                    req_valid;
  logic [CH-1:0]                    req_ready;
  logic [CH-1:0][7:0][7:0][11:0]    req_block;
  logic                             idct_valid;
  logic [CW-1:0]                    idct_channel;
  logic [7:0][7:0][11:0]            idct_block;
  logic                             idct_done;
  logic [CW-1:0]                    idct_done_ch;

  modport master (
    output req_valid,
    output req_block,
    output idct_done,
    output idct_done_ch,
    input  req_ready,
    input  idct_valid,
    input  idct_channel,
    input  idct_block
  );

  modport slave (
    input  req_valid,
    input  req_block,
    input  idct_done,
    input  idct_done_ch,
    output req_ready,
    output idct_valid,
    output idct_channel,
    output idct_block
  );
endinterface

// File: rtl/idct_block_scheduler.sv
// Round-robin sharing of one IDCT engine between CH block producers,
// with credit-bounded issue, completion tag checking and flush/drain.
module idct_block_scheduler #(
  parameter int CH           = 3,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  idct_block_scheduler_if.slave             bus,
  input  logic                              flush,
  output logic                              flush_done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err_tag,
  output logic                              err_underflow
);
  localparam int CW = $clog2(CH + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int PW = $clog2(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    FLUSHED
  } state_t;

  state_t                            state_q, state_d;
  logic [CW-1:0]                     rr_q, rr_d;
  logic                              pend_q, pend_d;
  logic [CW-1:0]                     chan_q, chan_d;
  logic [7:0][7:0][11:0]             blk_q, blk_d;
  logic [IW-1:0]                     infl_q, infl_d;
  logic [PW-1:0]                     wr_q, wr_d;
  logic [PW-1:0]                     rd_q, rd_d;
  logic [MAX_INFLIGHT-1:0][CW-1:0]   tags_q, tags_d;
  logic                              et_q, et_d;
  logic                              eu_q, eu_d;

  logic [CH-1:0]                     grant;
  logic                              gfound;
  logic [CW-1:0]                     gidx;
  logic [CW-1:0]                     rr_nxt;
  logic [IW:0]                       used;
  logic                              can_grant;
  logic                              pop;

  function automatic int wrap(input int a);
    return (a >= CH) ? a - CH : a;
  endfunction

  // Pending issue holds a credit so the IDCT never sees more than MAX_INFLIGHT.
  assign used = {1'b0, infl_q} + {{IW{1'b0}}, pend_q};
  assign can_grant = !rst && (state_q == RUN) &&
                     (used < (IW+1)'(MAX_INFLIGHT));

  always_comb begin
    grant  = '0;
    gfound = 1'b0;
    gidx   = '0;
    rr_nxt = rr_q;
    for (int k = 0; k < CH; k++) begin
      for (int j = 0; j < CH; j++) begin
        if (can_grant && !gfound && bus.req_valid[j] &&
            wrap(int'(rr_q) + k) == j) begin
          gfound   = 1'b1;
          grant[j] = 1'b1;
          gidx     = CW'(j);
          rr_nxt   = CW'(wrap(j + 1));
        end
      end
    end
  end

  assign bus.req_ready    = grant;
  assign bus.idct_valid   = pend_q;
  assign bus.idct_channel = chan_q;
  assign bus.idct_block   = blk_q;
  assign flush_done       = (state_q == FLUSHED);
  assign inflight         = infl_q;
  assign err_tag          = et_q;
  assign err_underflow    = eu_q;

  assign pop = bus.idct_done && (infl_q != '0);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    pend_d  = gfound;
    chan_d  = chan_q;
    blk_d   = blk_q;
    infl_d  = infl_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    tags_d  = tags_q;
    et_d    = et_q;
    eu_d    = eu_q;

    if (gfound) begin
      rr_d   = rr_nxt;
      chan_d = gidx;
      for (int j = 0; j < CH; j++) begin
        if (grant[j]) blk_d = bus.req_block[j];
      end
    end

    if (pend_q) begin
      tags_d[wr_q] = chan_q;
      wr_d         = wr_q + PW'(1);
    end

    if (bus.idct_done && (infl_q == '0)) eu_d = 1'b1;
    if (pop) begin
      if (tags_q[rd_q] != bus.idct_done_ch) et_d = 1'b1;
      rd_d = rd_q + PW'(1);
    end

    unique case ({pend_q, pop})
      2'b10:   infl_d = infl_q + IW'(1);
      2'b01:   infl_d = infl_q - IW'(1);
      default: infl_d = infl_q;
    endcase

    unique case (state_q)
      RUN: begin
        if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (!flush) state_d = RUN;
        else if (infl_q == '0 && !pend_q) state_d = FLUSHED;
      end
      FLUSHED: begin
        if (!flush) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      rr_q    <= '0;
      pend_q  <= 1'b0;
      chan_q  <= '0;
      blk_q   <= '0;
      infl_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      tags_q  <= '0;
      et_q    <= 1'b0;
      eu_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      chan_q  <= chan_d;
      blk_q   <= blk_d;
      infl_q  <= infl_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      tags_q  <= tags_d;
      et_q    <= et_d;
      eu_q    <= eu_d;
    end
  end
endmodule

// File: tb/tb_idct_block_scheduler.sv
// Directed bench for idct_block_scheduler with a cycle model,
// an issue scoreboard and a tag queue standing in for the IDCT.
module tb_idct_block_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       flush_done;
  logic [2:0] inflight;
  logic       err_tag;
  logic       err_underflow;

  always #5 clk = ~clk;

  idct_block_scheduler_if #(.CH(3)) bus();

  idct_block_scheduler #(.CH(3), .MAX_INFLIGHT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .flush         (flush),
    .flush_done    (flush_done),
    .inflight      (inflight),
    .err_tag       (err_tag),
    .err_underflow (err_underflow)
  );

  typedef struct {
    logic [1:0]   ch;
    logic [767:0] blk;
  } exp_t;

  exp_t       sbq[$];
  logic [1:0] mtags[$];
  int         dlog[$];
  int         compared = 0;
  int         mism = 0;

  int mstate;
  int mrr;
  int minfl;
  bit mpend;
  bit met;
  bit meu;

  task automatic chk(input string tag, input logic [767:0] obs,
                     input logic [767:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rand();
    logic [1:0] c;
    logic [2:0] r;
    logic [2:0] k;
    for (int ch = 0; ch < 3; ch++) begin
      for (int i = 0; i < 64; i++) begin
        c = 2'(ch);
        r = 3'(i / 8);
        k = 3'(i % 8);
        bus.req_block[c][r][k] = 12'($urandom);
      end
    end
  endtask

  function automatic logic [2:0] model_grant();
    int c;
    if (mstate != 0 || minfl + int'(mpend) >= 4) return 3'b000;
    for (int k = 0; k < 3; k++) begin
      c = (mrr + k) % 3;
      if (bus.req_valid[2'(c)]) return 3'(1 << c);
    end
    return 3'b000;
  endfunction

  task automatic model_reset();
    mstate = 0;
    mrr    = 0;
    minfl  = 0;
    mpend  = 0;
    met    = 0;
    meu    = 0;
    sbq.delete();
    mtags.delete();
  endtask

  task automatic cyc();
    logic [2:0] g;
    logic [1:0] ich;
    logic [1:0] head;
    exp_t       e;
    bit         pop;
    @(negedge clk);
    g   = model_grant();
    ich = 2'b00;
    for (int c = 0; c < 3; c++)
      if (bus.req_valid[2'(c)] && bus.req_ready[2'(c)]) dlog.push_back(c);
    chk("req_ready", bus.req_ready, g);
    chk("idct_valid", bus.idct_valid, mpend);
    if (mpend && sbq.size() > 0) begin
      e   = sbq.pop_front();
      ich = e.ch;
      chk("idct_channel", bus.idct_channel, e.ch);
      chk("idct_block", bus.idct_block, e.blk);
    end
    chk("inflight", inflight, minfl);
    chk("flush_done", flush_done, mstate == 2);
    chk("err_tag", err_tag, met);
    chk("err_underflow", err_underflow, meu);
    pop = bus.idct_done && minfl != 0;
    if (bus.idct_done && minfl == 0) meu = 1;
    if (pop && mtags.size() > 0) begin
      head = mtags.pop_front();
      if (head != bus.idct_done_ch) met = 1;
    end
    if (mpend) mtags.push_back(ich);
    case (mstate)
      0: if (flush) mstate = 1;
      1: if (!flush) mstate = 0;
         else if (minfl == 0 && !mpend) mstate = 2;
      default: if (!flush) mstate = 0;
    endcase
    minfl = minfl + int'(mpend) - int'(pop);
    mpend = (g != 3'b000);
    for (int c = 0; c < 3; c++) begin
      if (g[2'(c)]) begin
        e.ch  = 2'(c);
        e.blk = bus.req_block[2'(c)];
        sbq.push_back(e);
        mrr = (c + 1) % 3;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_done();
    bus.idct_done    = (mtags.size() > 0);
    bus.idct_done_ch = (mtags.size() > 0) ? mtags[0] : 2'b00;
  endtask

  task automatic drain();
    bus.req_valid = 3'b000;
    for (int n = 0; n < 30 && (mtags.size() > 0 || mpend); n++) begin
      set_done();
      cyc();
    end
    bus.idct_done = 1'b0;
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    #2;
    chk("rst_ready", bus.req_ready, 3'b000);
    chk("rst_valid", bus.idct_valid, 1'b0);
    chk("rst_chan", bus.idct_channel, 2'b00);
    chk("rst_block", bus.idct_block, 768'd0);
    chk("rst_infl", inflight, 3'd0);
    chk("rst_fdone", flush_done, 1'b0);
    chk("rst_etag", err_tag, 1'b0);
    chk("rst_eund", err_underflow, 1'b0);
    model_reset();
    bus.req_valid = 3'b000;
    bus.idct_done = 1'b0;
    flush         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [767:0] b5;

  initial begin
    rst              = 1'b1;
    flush            = 1'b0;
    bus.req_valid    = 3'b000;
    bus.idct_done    = 1'b0;
    bus.idct_done_ch = 2'b00;
    fill_rand();
    for (int i = 0; i < 64; i++) b5[i*12 +: 12] = 12'd5;
    @(posedge clk);
    #1;
    hard_reset();

    for (int i = 0; i < 64; i++) bus.req_block[1][3'(i/8)][3'(i%8)] = 12'd5;
    bus.req_valid = 3'b010;
    #1;
    chk("t1_ready", bus.req_ready, 3'b010);
    cyc();
    bus.req_valid = 3'b000;
    chk("t1_issue", bus.idct_valid, 1'b1);
    chk("t1_chan", bus.idct_channel, 2'd1);
    chk("t1_block", bus.idct_block, b5);
    cyc();
    chk("t1_infl", inflight, 3'd1);
    bus.idct_done    = 1'b1;
    bus.idct_done_ch = 2'd1;
    cyc();
    bus.idct_done = 1'b0;
    chk("t1_infl0", inflight, 3'd0);
    chk("t1_etag", err_tag, 1'b0);
    chk("t1_eund", err_underflow, 1'b0);
    cyc();

    hard_reset();
    fill_rand();
    dlog.delete();
    bus.req_valid = 3'b111;
    for (int n = 0; n < 40 && dlog.size() < 6; n++) begin
      set_done();
      cyc();
    end
    drain();
    chk("t2_count", dlog.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < dlog.size(); i++)
      chk("t2_order", dlog[i], i % 3);
    chk("t2_etag", err_tag, 1'b0);

    hard_reset();
    fill_rand();
    dlog.delete();
    bus.req_valid = 3'b111;
    repeat (8) cyc();
    chk("t3_issued", dlog.size(), 4);
    chk("t3_infl4", inflight, 3'd4);
    chk("t3_stall", bus.req_ready, 3'b000);
    set_done();
    cyc();
    bus.idct_done = 1'b0;
    chk("t3_regrant", bus.req_ready != 3'b000, 1'b1);
    cyc();
    chk("t3_issue", bus.idct_valid, 1'b1);
    chk("t3_infl3", inflight, 3'd3);
    set_done();
    cyc();
    bus.idct_done = 1'b0;
    chk("t3_keep", inflight, 3'd3);
    chk("t3_issued5", dlog.size(), 5);
    drain();
    chk("t3_infl0", inflight, 3'd0);

    hard_reset();
    fill_rand();
    bus.req_valid = 3'b001;
    cyc();
    bus.req_valid = 3'b100;
    cyc();
    bus.req_valid = 3'b000;
    cyc();
    cyc();
    chk("t4_infl2", inflight, 3'd2);
    bus.idct_done    = 1'b1;
    bus.idct_done_ch = 2'd2;
    cyc();
    chk("t4_etag", err_tag, 1'b1);
    chk("t4_eund0", err_underflow, 1'b0);
    bus.idct_done_ch = 2'd0;
    cyc();
    chk("t4_sticky", err_tag, 1'b1);
    chk("t4_infl0", inflight, 3'd0);
    cyc();
    bus.idct_done = 1'b0;
    chk("t4_eund", err_underflow, 1'b1);
    chk("t4_stay0", inflight, 3'd0);
    cyc();

    hard_reset();
    fill_rand();
    bus.req_valid = 3'b111;
    repeat (3) cyc();
    bus.req_valid = 3'b000;
    cyc();
    cyc();
    chk("t5_infl3", inflight, 3'd3);
    flush = 1'b1;
    cyc();
    bus.req_valid = 3'b001;
    cyc();
    chk("t5_nogrant", bus.req_ready, 3'b000);
    for (int d = 0; d < 2; d++) begin
      set_done();
      cyc();
      bus.idct_done = 1'b0;
      cyc();
    end
    chk("t5_notyet", flush_done, 1'b0);
    set_done();
    cyc();
    bus.idct_done = 1'b0;
    cyc();
    cyc();
    chk("t5_fdone", flush_done, 1'b1);
    flush = 1'b0;
    cyc();
    chk("t5_regrant", bus.req_ready, 3'b001);
    cyc();
    drain();

    hard_reset();
    fill_rand();
    bus.req_valid = 3'b111;
    repeat (4) cyc();
    chk("t6_infl3", inflight, 3'd3);
    hard_reset();
    bus.req_valid = 3'b111;
    #1;
    chk("t6_rr0", bus.req_ready, 3'b001);
    cyc();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
